// File: rtl/regs_arbiter_if.sv
// Core/debug side of the register-file arbiter: request operands, grants,
// returned read data and halt handshake.
interface regs_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr1;
  logic [ADDR_W-1:0] core_addr2;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic [DATA_W-1:0] core_rdata1;
  logic [DATA_W-1:0] core_rdata2;
  logic              core_rvalid;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;

  logic              dbg_halt;
  logic              halt_ack;

  modport master (
    output core_req, core_we, core_addr1, core_addr2, core_wdata,
    input  core_gnt, core_rdata1, core_rdata2, core_rvalid,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rdata, dbg_rvalid,
    output dbg_halt,
    input  halt_ack
  );

  modport slave (
    input  core_req, core_we, core_addr1, core_addr2, core_wdata,
    output core_gnt, core_rdata1, core_rdata2, core_rvalid,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rdata, dbg_rvalid,
    input  dbg_halt,
    output halt_ack
  );
endinterface

// File: rtl/regs_arbiter.sv
// Shares the register-file access path between the CPU core and a debug
// requester: core priority, bounded debug wait, and a halt mode.
module regs_arbiter #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  regs_arbiter_if.slave     bus,
  output logic              regs_we,
  output logic [ADDR_W-1:0] regs_addr1,
  output logic [ADDR_W-1:0] regs_addr2,
  output logic [DATA_W-1:0] regs_wr_data,
  input  logic [DATA_W-1:0] regs_rd1,
  input  logic [DATA_W-1:0] regs_rd2
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              core_gnt, dbg_gnt, halt_ack;
  logic [DATA_W-1:0] core_rdata1_q, core_rdata2_q, dbg_rdata_q;
  logic              core_rvalid_q, dbg_rvalid_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = bus.dbg_halt ? ST_HALT : ST_RUN;
  end

  // Grants are gated by n_reset so an access in flight at reset never writes.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    halt_ack = (state_q == ST_HALT);
    if (n_reset) begin
      if (state_q == ST_RUN) begin
        if (bus.core_req && !(bus.dbg_req && wait_cnt_q == MAX_W))
          core_gnt = 1'b1;
        else if (bus.dbg_req)
          dbg_gnt = 1'b1;
      end else begin
        dbg_gnt = bus.dbg_req;
      end
    end
  end

  always_comb begin
    wait_cnt_d = 4'd0;
    if (bus.dbg_req && !dbg_gnt)
      wait_cnt_d = (wait_cnt_q >= MAX_W) ? MAX_W : wait_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) wait_cnt_q <= 4'd0;
    else          wait_cnt_q <= wait_cnt_d;
  end

  // With no grant the core operands stay on the bus; only we is suppressed.
  always_comb begin
    regs_addr1   = bus.core_addr1;
    regs_addr2   = bus.core_addr2;
    regs_wr_data = bus.core_wdata;
    regs_we      = core_gnt & bus.core_we;
    if (dbg_gnt) begin
      regs_addr1   = '0;
      regs_addr2   = bus.dbg_addr;
      regs_wr_data = bus.dbg_wdata;
      regs_we      = bus.dbg_we;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      core_rdata1_q <= '0;
      core_rdata2_q <= '0;
      dbg_rdata_q   <= '0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
    end else begin
      core_rvalid_q <= core_gnt;
      dbg_rvalid_q  <= dbg_gnt;
      if (core_gnt) begin
        core_rdata1_q <= regs_rd1;
        core_rdata2_q <= regs_rd2;
      end
      if (dbg_gnt)
        dbg_rdata_q <= regs_rd2;
    end
  end

  assign bus.core_gnt    = core_gnt;
  assign bus.dbg_gnt     = dbg_gnt;
  assign bus.halt_ack    = halt_ack;
  assign bus.core_rdata1 = core_rdata1_q;
  assign bus.core_rdata2 = core_rdata2_q;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.dbg_rdata   = dbg_rdata_q;
  assign bus.dbg_rvalid  = dbg_rvalid_q;

endmodule
